rule_writer: RTL
================

# rule_writer

Downstream stage of the parser. Accepts 16-bit reduction rules as they are emitted, packs two rules per 32-bit word, buffers words in an internal FIFO and writes them sequentially to memory over the AXI write channels (AW/W/B), which the core currently ties off. The core's rule stream has no back-pressure, so the block buffers internally and flags overflow instead of stalling the parser.

## Interface
- FIFO_DEPTH, 16: word FIFO depth; power of two, ≥ 2.
- C_M_AXI_ADDR_WIDTH, 32: AXI address width.
- C_M_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.

Ports:
- CLK  in  1  single clock for all logic.
- RST  in  1  reset; asynchronous and active-high.
- I_VALID  in  1  rule strobe from the parser's O_VALID.
- I_RULE  in  16  rule code from the parser's O_RULE.
- I_START  in  1  pulse. Latches I_BASE_ADDR and clears the word index and O_WORDS. Honoured only while O_BUSY=0.
- I_BASE_ADDR  in  32  destination base address; must be 4-byte aligned.
- I_FLUSH  in  1  pulse. Emits any pending half-word.
- O_BUSY  out  1  high if any of these is true: half-word pending, FIFO non-empty, or FSM not IDLE.
- O_WORDS  out  16  count of words acknowledged by B.
- O_ERR  out  1  sticky error flag (see Configuration).
- M_AXI_AW* out  full AW channel. AWLEN=0, AWSIZE=3'b010, AWBURST=2'b01, AWCACHE=4'b0011; all other AW fields 0.
- M_AXI_AWREADY in 1.
- M_AXI_W* out  full W channel. WSTRB=4'b1111, WLAST=1 whenever WVALID=1.
- M_AXI_WREADY in 1.
- M_AXI_BRESP in 2.
- M_AXI_BVALID in 1.
- M_AXI_BREADY out 1.

## Operation
- Packer:
  - First rule of a pair goes to [15:0] and sets `half` to 1.
  - Second rule forms word {rule, low}. It is pushed to the FIFO on the next edge and `half` clears.
- I_FLUSH with half=1 pushes {16'h0000, low}. I_FLUSH with half=0 does nothing.
- I_VALID and I_FLUSH in the same cycle: the rule is packed first, then the flush applies to the resulting state.
- Push when FIFO full:
  - The push is accepted only if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is raised.
- FSM:
  - IDLE → WRITE when the FIFO is non-empty. Drives AWADDR = base + 4·index, WDATA = FIFO head.
  - WRITE: AWVALID and WVALID both rise on entry. Each falls independently after its own handshake (VALID&READY). Once both handshakes are done → RESP.
  - RESP: BREADY=1. On BVALID: pop the FIFO, increment index and O_WORDS, → IDLE.
- The index and O_WORDS wrap modulo 2^16 silently.
- Reset mid-transaction:
  - All state clears immediately: FIFO empty, half=0, FSM IDLE, O_ERR=0, base=0.
  - The outstanding AXI transaction is abandoned; the interconnect must be reset alongside.

## Timing
- Reset values: AWVALID=0, WVALID=0, BREADY=0, AWADDR=0, WDATA=0, O_BUSY=0, O_WORDS=0, O_ERR=0.
- All outputs are registered.
- Second rule at edge n → word in FIFO at edge n+1 → FSM enters WRITE, VALIDs high, at edge n+2.
- Best case with READYs high: AW/W handshake at n+3, B accepted at n+4 (BVALID the cycle after). One word per 3 cycles minimum.
- AWVALID and WVALID are held stable until their handshakes; address and data do not change while VALID is high.
- I_START while O_BUSY=1 is ignored.

## Configuration
- RULE_WRITER_ERR_EN defined:
  - O_ERR is set on FIFO overflow, or on a B handshake with BRESP≠2'b00.
  - O_ERR clears only on RST or on an accepted I_START.
  - A failed write still pops and advances the index.
- Undefined: O_ERR is tied 0, overflow is silently dropped, and BRESP is ignored.

## Test plan
- I_START with base 0x1000; rules 0x0003, 0x0007 back to back, READYs high → one write to 0x1000 with data 0x00070003, O_WORDS=1, O_BUSY=0 at the end.
- Three rules (0x0001, 0x0002, 0x0005) then I_FLUSH → writes 0x00020001 @0x1000 and 0x00000005 @0x1004.
- Stress the AW/W handshakes:
  - Stimulus: AWREADY delayed 4 cycles while WREADY is immediate, then the reverse.
  - Required: WVALID drops after its own handshake; RESP is entered only after both handshakes; data is unchanged throughout.
- Overflow: BVALID held low, 2·(FIFO_DEPTH+2) rules injected:
  - The FIFO holds FIFO_DEPTH words and the extras are dropped.
  - O_ERR=1 with the macro defined, 0 without.
- BRESP=2'b10 on the first write (macro defined) → O_ERR=1 and index advances to 0x1004.
- Assert RST while in WRITE with AWVALID=1 → all outputs return to reset values asynchronously before the next edge.

Source files
------------

// File: rtl/rule_writer_if.sv
// AXI4 write-only master bundle (AW/W/B) used by rule_writer.
// The master modport is the rule writer; the slave modport is the memory side.
interface rule_writer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
   logic [7:0]              M_AXI_AWLEN;
   logic [2:0]              M_AXI_AWSIZE;
   logic [1:0]              M_AXI_AWBURST;
   logic                    M_AXI_AWLOCK;
   logic [3:0]              M_AXI_AWCACHE;
   logic [2:0]              M_AXI_AWPROT;
   logic [3:0]              M_AXI_AWQOS;
   logic                    M_AXI_AWVALID;
   logic                    M_AXI_AWREADY;
   logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
   logic                    M_AXI_WLAST;
   logic                    M_AXI_WVALID;
   logic                    M_AXI_WREADY;
   logic [1:0]              M_AXI_BRESP;
   logic                    M_AXI_BVALID;
   logic                    M_AXI_BREADY;

   modport master (
      output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK,
             M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
             M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
      input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
   );

   modport slave (
      input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK,
             M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
             M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
      output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
   );
endinterface

// File: rtl/rule_writer.sv
// Packs 16-bit parser rules two per word, buffers them and writes them out as single-beat AXI writes.
// Define RULE_WRITER_ERR_EN to enable the sticky O_ERR flag (FIFO overflow, non-OKAY BRESP).
//
// state    | meaning
// ST_IDLE  | waiting for a word at the FIFO head
// ST_WRITE | AWVALID/WVALID raised, each drops on its own handshake
// ST_RESP  | BREADY high, waiting for the write response
module rule_writer #(
   parameter int FIFO_DEPTH         = 16,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          I_VALID,
   input  logic [15:0]                   I_RULE,
   input  logic                          I_START,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_BASE_ADDR,
   input  logic                          I_FLUSH,
   output logic                          O_BUSY,
   output logic [15:0]                   O_WORDS,
   output logic                          O_ERR,
   rule_writer_if.master                 m_axi
);
   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_WRITE = 2'b01;
   localparam logic [1:0] ST_RESP  = 2'b10;

   logic [DW-1:0] fifo_mem [FIFO_DEPTH];

   logic          half_q, half_d;
   logic [15:0]   low_q, low_d;
   logic          pend_q, pend_d;
   logic [DW-1:0] pend_word_q, pend_word_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [1:0]    state_q, state_d;
   logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic [AW-1:0] awaddr_q, awaddr_d, base_q, base_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [15:0]   index_q, index_d, words_q, words_d;
   logic          busy_q, busy_d;
   logic          push, pop, overflow;

   always_comb begin
      half_d      = half_q;
      low_d       = low_q;
      pend_d      = 1'b0;
      pend_word_d = pend_word_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      base_d      = base_q;
      index_d     = index_q;
      words_d     = words_q;
      push        = 1'b0;
      pop         = 1'b0;
      overflow    = 1'b0;

      // a rule arriving with a flush is packed first, the flush then sees the updated half
      if (I_VALID) begin
         if (half_q) begin
            pend_d      = 1'b1;
            pend_word_d = DW'({I_RULE, low_q});
            half_d      = 1'b0;
         end else begin
            low_d  = I_RULE;
            half_d = 1'b1;
         end
      end
      if (I_FLUSH && half_d) begin
         pend_d      = 1'b1;
         pend_word_d = DW'({16'h0000, low_d});
         half_d      = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               state_d   = ST_WRITE;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               awaddr_d  = base_q + AW'({index_q, 2'b00});
               wdata_d   = fifo_mem[rd_ptr_q];
            end
         end
         ST_WRITE: begin
            if (awvalid_q && m_axi.M_AXI_AWREADY) awvalid_d = 1'b0;
            if (wvalid_q && m_axi.M_AXI_WREADY)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = ST_RESP;
               bready_d = 1'b1;
            end
         end
         ST_RESP: begin
            if (m_axi.M_AXI_BVALID) begin
               pop      = 1'b1;
               bready_d = 1'b0;
               index_d  = index_q + 16'd1;
               words_d  = words_q + 16'd1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // a full FIFO still accepts a word when the head leaves in the same cycle
      if (pend_q) begin
         if (count_q != FULL_CNT || pop) push     = 1'b1;
         else                            overflow = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      if (I_START && !busy_q) begin
         base_d  = I_BASE_ADDR;
         index_d = '0;
         words_d = '0;
      end

      busy_d = half_d | pend_d | (count_d != '0) | (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         half_q      <= 1'b0;
         low_q       <= '0;
         pend_q      <= 1'b0;
         pend_word_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= ST_IDLE;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         base_q      <= '0;
         index_q     <= '0;
         words_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         half_q      <= half_d;
         low_q       <= low_d;
         pend_q      <= pend_d;
         pend_word_q <= pend_word_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         base_q      <= base_d;
         index_q     <= index_d;
         words_q     <= words_d;
         busy_q      <= busy_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) fifo_mem[wr_ptr_q] <= pend_word_q;
   end

`ifdef RULE_WRITER_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (I_START && !busy_q) err_d = 1'b0;
      if (overflow || (pop && m_axi.M_AXI_BRESP != 2'b00)) err_d = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign O_ERR = err_q;
`else
   logic unused_err_inputs;
   assign unused_err_inputs = ^{m_axi.M_AXI_BRESP, overflow};
   assign O_ERR = 1'b0;
`endif

   assign O_BUSY  = busy_q;
   assign O_WORDS = words_q;

   assign m_axi.M_AXI_AWADDR  = awaddr_q;
   assign m_axi.M_AXI_AWLEN   = 8'd0;
   assign m_axi.M_AXI_AWSIZE  = 3'b010;
   assign m_axi.M_AXI_AWBURST = 2'b01;
   assign m_axi.M_AXI_AWLOCK  = 1'b0;
   assign m_axi.M_AXI_AWCACHE = 4'b0011;
   assign m_axi.M_AXI_AWPROT  = 3'b000;
   assign m_axi.M_AXI_AWQOS   = 4'b0000;
   assign m_axi.M_AXI_AWVALID = awvalid_q;
   assign m_axi.M_AXI_WDATA   = wdata_q;
   assign m_axi.M_AXI_WSTRB   = '1;
   assign m_axi.M_AXI_WLAST   = 1'b1;
   assign m_axi.M_AXI_WVALID  = wvalid_q;
   assign m_axi.M_AXI_BREADY  = bready_q;
endmodule
